// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard control bundle: decode/execute/memory hazard inputs and the
// stage enable, flush and bubble outputs, plus debug/status outputs.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       IF_ID_reg_rs;
    logic [4:0]       IF_ID_reg_rt;
    logic             IF_ID_memWrite;
    logic             ID_EX_memRead;
    logic [4:0]       ID_EX_reg_rt;
    logic             branch_taken;
    logic             mem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             IF_ID_write;
    logic             ID_EX_write;
    logic             EX_MEM_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             MEM_WB_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       state;

    modport master (
        output IF_ID_reg_rs, IF_ID_reg_rt, IF_ID_memWrite, ID_EX_memRead, ID_EX_reg_rt,
               branch_taken, mem_req, dmem_ready,
        input  pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_bubble,
               MEM_WB_bubble, mem_timeout, stall_cycles, state
    );

    modport slave (
        input  IF_ID_reg_rs, IF_ID_reg_rt, IF_ID_memWrite, ID_EX_memRead, ID_EX_reg_rt,
               branch_taken, mem_req, dmem_ready,
        output pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_bubble,
               MEM_WB_bubble, mem_timeout, stall_cycles, state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory-wait freeze, taken-branch flush and load-use
// stall, with a sticky memory timeout flag and a saturating stall counter.
module hazard_control_unit #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_control_unit_if.slave bus
);
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic freeze;
    logic load_use;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_bubble, mem_wb_bubble;

    assign freeze = bus.mem_req & ~bus.dmem_ready;

    // Store data operand is excluded: the memory stage forwards it.
    assign load_use = bus.ID_EX_memRead & (bus.ID_EX_reg_rt != 5'd0) &
                      ((bus.ID_EX_reg_rt == bus.IF_ID_reg_rs) |
                       ((bus.ID_EX_reg_rt == bus.IF_ID_reg_rt) & ~bus.IF_ID_memWrite));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            wait_cnt_q    <= 5'd0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_q       <= stall_d;
        end
    end

    always_comb begin
        state_d       = StRun;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q |
                        ((state_q == StMemWait) & freeze & ({27'd0, wait_cnt_q} == TIMEOUT));
        stall_d       = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d    = StMemWait;
                    wait_cnt_d = 5'd0;
                end
            end
            StMemWait: begin
                state_d = freeze ? StMemWait : StRun;
                if (wait_cnt_q != 5'd31) begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Priority: reset > freeze > branch flush > load-use stall.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (bus.branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.IF_ID_write   = if_id_write;
    assign bus.ID_EX_write   = id_ex_write;
    assign bus.EX_MEM_write  = ex_mem_write;
    assign bus.IF_ID_flush   = if_id_flush;
    assign bus.ID_EX_bubble  = id_ex_bubble;
    assign bus.MEM_WB_bubble = mem_wb_bubble;
    assign bus.mem_timeout   = mem_timeout_q;
    assign bus.stall_cycles  = stall_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a default instance plus a second one
// with TIMEOUT=3 and a 3-bit stall counter sharing the same stimulus.
module tb_hazard_control_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    // {pc, IF_ID, ID_EX, EX_MEM write, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble}
    localparam logic [6:0] CtlNorm   = 7'b1111_000;
    localparam logic [6:0] CtlReset  = 7'b0000_111;
    localparam logic [6:0] CtlFreeze = 7'b0000_001;
    localparam logic [6:0] CtlBranch = 7'b1111_110;
    localparam logic [6:0] CtlLdUse  = 7'b0011_010;

    hazard_control_unit_if #(.CNT_W(16)) hif ();
    hazard_control_unit_if #(.CNT_W(3))  hif3 ();

    hazard_control_unit #(.TIMEOUT(15), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    hazard_control_unit #(.TIMEOUT(3), .CNT_W(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif3)
    );

    assign hif3.IF_ID_reg_rs   = hif.IF_ID_reg_rs;
    assign hif3.IF_ID_reg_rt   = hif.IF_ID_reg_rt;
    assign hif3.IF_ID_memWrite = hif.IF_ID_memWrite;
    assign hif3.ID_EX_memRead  = hif.ID_EX_memRead;
    assign hif3.ID_EX_reg_rt   = hif.ID_EX_reg_rt;
    assign hif3.branch_taken   = hif.branch_taken;
    assign hif3.mem_req        = hif.mem_req;
    assign hif3.dmem_ready     = hif.dmem_ready;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {hif.pc_write, hif.IF_ID_write, hif.ID_EX_write, hif.EX_MEM_write,
                hif.IF_ID_flush, hif.ID_EX_bubble, hif.MEM_WB_bubble};
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.IF_ID_reg_rs   = 5'd0;
        hif.IF_ID_reg_rt   = 5'd0;
        hif.IF_ID_memWrite = 1'b0;
        hif.ID_EX_memRead  = 1'b0;
        hif.ID_EX_reg_rt   = 5'd0;
        hif.branch_taken   = 1'b0;
        hif.mem_req        = 1'b0;
        hif.dmem_ready     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        check("reset_ctl", 32'(ctl()), 32'(CtlReset));
        tick();
        tick();
        check("reset_state", 32'(hif.state), 32'd0);
        check("reset_stall", 32'(hif.stall_cycles), 32'd0);
        check("reset_timeout", 32'(hif.mem_timeout), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_ctl", 32'(ctl()), 32'(CtlNorm));

        // Load r5 in EX, decode reads rs=5: one stall cycle.
        hif.ID_EX_memRead = 1'b1;
        hif.ID_EX_reg_rt  = 5'd5;
        hif.IF_ID_reg_rs  = 5'd5;
        hif.mem_req       = 1'b1;
        hif.dmem_ready    = 1'b1;
        #1;
        check("lduse_ctl", 32'(ctl()), 32'(CtlLdUse));
        tick();
        idle();
        #1;
        check("lduse_after_ctl", 32'(ctl()), 32'(CtlNorm));
        check("lduse_stall", 32'(hif.stall_cycles), 32'd1);

        // Store data operand on rt does not stall; plain rt use does; r0 never does.
        hif.ID_EX_memRead  = 1'b1;
        hif.ID_EX_reg_rt   = 5'd5;
        hif.IF_ID_reg_rs   = 5'd3;
        hif.IF_ID_reg_rt   = 5'd5;
        hif.IF_ID_memWrite = 1'b1;
        #1;
        check("store_rt_ctl", 32'(ctl()), 32'(CtlNorm));
        hif.IF_ID_memWrite = 1'b0;
        #1;
        check("rt_use_ctl", 32'(ctl()), 32'(CtlLdUse));
        hif.ID_EX_reg_rt = 5'd0;
        hif.IF_ID_reg_rs = 5'd0;
        hif.IF_ID_reg_rt = 5'd0;
        #1;
        check("r0_ctl", 32'(ctl()), 32'(CtlNorm));
        tick();
        check("r0_stall", 32'(hif.stall_cycles), 32'd1);

        // Four-cycle memory wait.
        idle();
        hif.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wait_ctl", 32'(ctl()), 32'(CtlFreeze));
            check("wait_state", 32'(hif.state), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        hif.dmem_ready = 1'b1;
        #1;
        check("ready_ctl", 32'(ctl()), 32'(CtlNorm));
        check("ready_state", 32'(hif.state), 32'd1);
        tick();
        idle();
        check("wait_back_run", 32'(hif.state), 32'd0);
        check("wait_stall", 32'(hif.stall_cycles), 32'd5);
        check("wait_timeout", 32'(hif.mem_timeout), 32'd0);

        // Ten-cycle wait: TIMEOUT=3 instance trips and sticks, default does not.
        hif.mem_req = 1'b1;
        tick();
        tick();
        check("to3_early", 32'(hif3.mem_timeout), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("to3_set", 32'(hif3.mem_timeout), 32'd1);
        check("to15_clear", 32'(hif.mem_timeout), 32'd0);
        hif.dmem_ready = 1'b1;
        tick();
        idle();
        tick();
        check("to3_sticky", 32'(hif3.mem_timeout), 32'd1);
        check("long_stall", 32'(hif.stall_cycles), 32'd15);
        check("stall_sat", 32'(hif3.stall_cycles), 32'd7);

        // Branch together with load-use flushes rather than stalls.
        hif.branch_taken  = 1'b1;
        hif.ID_EX_memRead = 1'b1;
        hif.ID_EX_reg_rt  = 5'd5;
        hif.IF_ID_reg_rs  = 5'd5;
        #1;
        check("br_lduse_ctl", 32'(ctl()), 32'(CtlBranch));
        tick();
        check("br_stall", 32'(hif.stall_cycles), 32'd15);
        hif.mem_req = 1'b1;
        #1;
        check("br_frozen_ctl", 32'(ctl()), 32'(CtlFreeze));
        tick();
        check("br_frozen2_ctl", 32'(ctl()), 32'(CtlFreeze));
        tick();
        hif.dmem_ready = 1'b1;
        #1;
        check("br_release_ctl", 32'(ctl()), 32'(CtlBranch));
        tick();
        idle();
        check("br_frozen_stall", 32'(hif.stall_cycles), 32'd17);

        // Reset in the middle of a memory wait.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        hif.mem_req = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_state", 32'(hif.state), 32'd1);
        check("pre_rst_stall", 32'(hif.stall_cycles), 32'd7);
        check("pre_rst_to3", 32'(hif3.mem_timeout), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_over_freeze", 32'(ctl()), 32'(CtlReset));
        tick();
        check("mid_rst_state", 32'(hif.state), 32'd0);
        check("mid_rst_stall", 32'(hif.stall_cycles), 32'd0);
        check("mid_rst_timeout", 32'(hif3.mem_timeout), 32'd0);
        rst_n = 1'b1;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: wait-cycle count at which mem_timeout sets.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IF_ID_reg_rs, IF_ID_reg_rt  input  5 each  source registers of the instruction in decode.
REQ-006 SHALL have port IF_ID_memWrite  input  1  the decode instruction is a store.
REQ-007 SHALL have port ID_EX_memRead  input  1  the execute instruction is a load.
REQ-008 SHALL have port ID_EX_reg_rt  input  5  load destination register in execute.
REQ-009 SHALL have port branch_taken  input  1  the branch resolved in execute is taken.
REQ-010 SHALL have port mem_req  input  1  the memory-stage instruction accesses data memory.
REQ-011 SHALL have port dmem_ready  input  1  data memory completes the access this cycle.
REQ-012 SHALL have ports pc_write, IF_ID_write, ID_EX_write, EX_MEM_write  output  1 each  register load enables.
REQ-013 SHALL have ports IF_ID_flush, ID_EX_bubble, MEM_WB_bubble  output  1 each  zero the control fields of that register on load.
REQ-014 SHALL have port mem_timeout  output  1  sticky flag: a memory wait exceeded TIMEOUT.
REQ-015 SHALL have port stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0.
REQ-016 SHALL have port state  output  2  current FSM state, for debug.

Function
REQ-017 SHALL implement FSM states RUN=2'b00 and MEM_WAIT=2'b01; codes 2'b10 and 2'b11 SHALL go to RUN.
REQ-018 SHALL compute enables, flush and bubble combinationally from state and inputs (Mealy), with zero added latency.
REQ-019 SHALL define freeze = mem_req & ~dmem_ready in any state.
REQ-020 During freeze, SHALL drive pc_write, IF_ID_write, ID_EX_write and EX_MEM_write to 0, MEM_WB_bubble to 1, IF_ID_flush to 0 and ID_EX_bubble to 0.
REQ-021 SHALL move RUN->MEM_WAIT on freeze, stay in MEM_WAIT while freeze holds, and move MEM_WAIT->RUN when dmem_ready=1 or mem_req=0.
REQ-022 SHALL use a 5-bit wait counter: clear it on RUN->MEM_WAIT, increment it each cycle in MEM_WAIT, and saturate it at 31.
REQ-023 SHALL set mem_timeout when the wait counter equals TIMEOUT while still frozen; it SHALL stay set until reset, and the FSM SHALL keep waiting.
REQ-024 When not frozen and branch_taken=1, SHALL drive IF_ID_flush=1, ID_EX_bubble=1, pc_write=1 and all write enables 1.
REQ-025 SHALL define load_use = ID_EX_memRead & (ID_EX_reg_rt!=0) & ((ID_EX_reg_rt==IF_ID_reg_rs) | ((ID_EX_reg_rt==IF_ID_reg_rt) & ~IF_ID_memWrite)).
- A store's data operand is excluded because memory-stage data forwarding covers it.
REQ-026 When not frozen, branch_taken=0 and load_use=1, SHALL drive pc_write=0, IF_ID_write=0 and ID_EX_bubble=1, with ID_EX_write=1 and EX_MEM_write=1.
REQ-027 Priority SHALL be: reset > freeze > branch flush > load-use; branch plus load-use together SHALL flush and not stall.
REQ-028 When no condition applies, SHALL drive all write enables 1 and all flush/bubble outputs 0.
REQ-029 SHALL hold branch_taken arriving during freeze and apply it on the first unfrozen cycle; EX is held, so the input persists.
REQ-030 SHALL increment stall_cycles on each non-reset cycle with pc_write=0 and saturate it at 2^CNT_W-1.

Reset
REQ-031 While rst_n=0, SHALL drive all write enables 0 and IF_ID_flush, ID_EX_bubble and MEM_WB_bubble 1.
REQ-032 On a clock edge with rst_n=0, SHALL load state=RUN, wait counter=0, mem_timeout=0 and stall_cycles=0.
- This applies mid-MEM_WAIT as well; there SHALL be no asynchronous path.

Verification
REQ-033 Load r5 in EX, decode reads rs=5, memory ready -> one cycle pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle all enables 1; stall_cycles=1.
REQ-034 Load r5, decode store with rt=5, rs=3 -> no stall, all enables 1; load r0 with rs=0 -> no stall.
REQ-035 mem_req=1, dmem_ready=0 for 4 cycles then 1 -> four cycles with EX_MEM_write=0 and MEM_WB_bubble=1, state=01, then RUN; stall_cycles=4; mem_timeout=0.
REQ-036 TIMEOUT=3, dmem_ready held 0 for 10 cycles -> mem_timeout rises after the 3rd wait cycle and stays 1 after ready returns.
REQ-037 branch_taken=1 with load_use=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; same pair during freeze -> flush on the first cycle after dmem_ready.
REQ-038 rst_n=0 for one edge during MEM_WAIT with stall_cycles=7 -> state=00, stall_cycles=0, mem_timeout=0 after that edge.
